// File: rtl/async_fifo_core.sv
// Single-clock FIFO with registered read data, occupancy count, almost flags
// and one-cycle overflow/underflow pulses on rejected requests.
module async_fifo_core #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ALMOST_MARGIN = 2
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                DEPTH        = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE      = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0] AFULL_LEVEL  = (ADDR_WIDTH + 1)'(DEPTH - ALMOST_MARGIN);
    localparam logic [ADDR_WIDTH:0] AEMPTY_LEVEL = (ADDR_WIDTH + 1)'(ALMOST_MARGIN);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
    logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_accept, rd_accept;

    // One extra pointer bit distinguishes full from empty when the addresses match.
    assign empty        = (wptr_q == rptr_q);
    assign full         = (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]) &&
                          (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);
    assign count        = wptr_q - rptr_q;
    assign almost_full  = (count >= AFULL_LEVEL);
    assign almost_empty = (count <= AEMPTY_LEVEL);

    assign wr_accept = wr_en && !full;
    assign rd_accept = rd_en && !empty;

    // NOTE: every signal gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        rd_data_d   = rd_data_q;
        overflow_d  = wr_en && full;
        underflow_d = rd_en && empty;
        if (wr_accept) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (rd_accept) begin
            rptr_d    = rptr_q + PTR_ONE;
            rd_data_d = mem[rptr_q[ADDR_WIDTH-1:0]];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            rd_data_q   <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            rd_data_q   <= rd_data_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: storage is deliberately not reset; clearing the pointers is enough to discard it.
    always_ff @(posedge wr_clk) begin
        if (!wr_rst && wr_accept) begin
            mem[wptr_q[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    assign rd_data   = rd_data_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_async_fifo_core.sv
// Randomized and directed bench for async_fifo_core against a queue-based
// reference model of the FIFO behaviour.
module tb_async_fifo_core;

    localparam int DW     = 8;
    localparam int AW     = 4;
    localparam int DEPTH  = 16;
    localparam int MARGIN = 2;

    logic          wr_clk = 1'b0;
    logic          wr_rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;
    logic [DW-1:0] rd_data;
    logic [AW:0]   count;

    int vectors    = 0;
    int miscompares = 0;
    int cycle      = 0;

    // Reference model state
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_rd_data = '0;
    logic          exp_overflow = 1'b0;
    logic          exp_underflow = 1'b0;

    always #5 wr_clk = ~wr_clk;

    async_fifo_core #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .ALMOST_MARGIN(MARGIN)
    ) dut (
        .wr_clk      (wr_clk),
        .wr_rst      (wr_rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .empty       (empty),
        .count       (count),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cycle, observed, expected);
        end
    endtask

    // Apply one cycle of stimulus, advance the model, then compare every output.
    task automatic step(input logic rst, input logic we, input logic [DW-1:0] wd, input logic re);
        int size_before;
        wr_rst  = rst;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        @(posedge wr_clk);
        size_before = model_q.size();
        if (rst) begin
            model_q.delete();
            exp_rd_data   = '0;
            exp_overflow  = 1'b0;
            exp_underflow = 1'b0;
        end else begin
            exp_overflow  = we && (size_before == DEPTH);
            exp_underflow = re && (size_before == 0);
            if (re && size_before != 0) exp_rd_data = model_q.pop_front();
            if (we && size_before != DEPTH) model_q.push_back(wd);
        end
        #1;
        cycle++;
        check("count",        32'(count),        32'(model_q.size()));
        check("empty",        32'(empty),        32'(model_q.size() == 0));
        check("full",         32'(full),         32'(model_q.size() == DEPTH));
        check("almost_full",  32'(almost_full),  32'(model_q.size() >= DEPTH - MARGIN));
        check("almost_empty", 32'(almost_empty), 32'(model_q.size() <= MARGIN));
        check("rd_data",      32'(rd_data),      32'(exp_rd_data));
        check("overflow",     32'(overflow),     32'(exp_overflow));
        check("underflow",    32'(underflow),    32'(exp_underflow));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_write(input logic [DW-1:0] wd);
        step(1'b0, 1'b1, wd, 1'b0);
    endtask

    task automatic do_read();
        step(1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, '0, 1'b0);
    endtask

    initial begin
        int bias_wr;
        int bias_rd;

        // Reset state
        do_reset();
        check("reset_empty",     32'(empty),        32'd1);
        check("reset_almost_em", 32'(almost_empty), 32'd1);
        check("reset_full",      32'(full),         32'd0);

        // Ten writes, idle, ten reads in order
        for (int i = 1; i <= 10; i++) do_write(DW'(i));
        idle();
        check("ten_count", 32'(count), 32'd10);
        for (int i = 1; i <= 10; i++) begin
            do_read();
            check("ten_order", 32'(rd_data), 32'(i));
        end
        check("ten_empty", 32'(empty), 32'd1);

        // Fill to DEPTH, rejected 17th write, drain
        do_reset();
        for (int i = 0; i < DEPTH; i++) do_write(DW'(8'h10 + i));
        check("fill_full",  32'(full),  32'd1);
        check("fill_count", 32'(count), 32'd16);
        do_write(8'hFF);
        check("fill_overflow", 32'(overflow), 32'd1);
        idle();
        check("fill_ovf_clear", 32'(overflow), 32'd0);
        // Full with simultaneous write and read: write is rejected, read proceeds
        step(1'b0, 1'b1, 8'hEE, 1'b1);
        check("full_wr_rd_count", 32'(count),    32'd15);
        check("full_wr_rd_ovf",   32'(overflow), 32'd1);
        check("full_wr_rd_data",  32'(rd_data),  32'h10);
        for (int i = 1; i < DEPTH; i++) do_read();
        check("fill_last", 32'(rd_data), 32'h1F);

        // Underflow from reset for two cycles
        do_reset();
        do_read();
        check("uf1", 32'(underflow), 32'd1);
        do_read();
        check("uf2",      32'(underflow), 32'd1);
        check("uf_data",  32'(rd_data),   32'd0);
        check("uf_empty", 32'(empty),     32'd1);
        // Empty with simultaneous write and read: read is rejected, write proceeds
        step(1'b0, 1'b1, 8'h5A, 1'b1);
        check("empty_wr_rd_count", 32'(count),     32'd1);
        check("empty_wr_rd_uf",    32'(underflow), 32'd1);

        // Concurrent write and read at count=5
        do_reset();
        for (int i = 0; i < 5; i++) do_write(DW'(8'h30 + i));
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, DW'(8'h40 + i), 1'b1);
            check("concurrent_count", 32'(count),   32'd5);
            check("concurrent_data",  32'(rd_data), 32'(8'h30 + i));
        end
        for (int i = 0; i < 5; i++) do_read();

        // Interleaved bursts of 12 and 8 across the pointer wrap
        do_reset();
        for (int i = 0; i < 12; i++) do_write(DW'(8'h80 + i));
        for (int i = 0; i < 8; i++) do_read();
        for (int i = 12; i < 20; i++) do_write(DW'(8'h80 + i));
        for (int i = 0; i < 12; i++) do_read();
        check("wrap_last", 32'(rd_data), 32'h93);

        // Reset mid-operation discards stored words
        for (int i = 0; i < 6; i++) do_write(DW'(8'hA0 + i));
        do_reset();
        do_read();
        check("rst_mid_empty", 32'(empty),     32'd1);
        check("rst_mid_count", 32'(count),     32'd0);
        check("rst_mid_uf",    32'(underflow), 32'd1);
        check("rst_mid_data",  32'(rd_data),   32'd0);

        // Reset has priority over simultaneous requests
        do_write(8'h11);
        step(1'b1, 1'b1, 8'h22, 1'b1);
        check("rst_prio_count", 32'(count), 32'd0);

        // Randomized traffic with drifting write/read bias to visit full and empty
        bias_wr = 50;
        bias_rd = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) begin
                bias_wr = int'($urandom_range(10, 90));
                bias_rd = int'($urandom_range(10, 90));
            end
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < bias_wr,
                 DW'($urandom),
                 $urandom_range(0, 99) < bias_rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
